// File: rtl/lbm_pkg.sv
// Shared lattice types for the collision/streaming datapath.
// cell_t carries the 9 distribution bytes of one grid cell.
package lbm_pkg;

  typedef logic [8:0][7:0] cell_t;

  localparam int GRID_W = 64;
  localparam int GRID_H = 48;
  localparam int NCELLS = GRID_W * GRID_H;
  localparam logic [7:0] BARRIER_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } sweep_state_e;

endpackage

// File: rtl/collision_sweep_if.sv
// Sweep-side bus: control, BRAM read/write ports and collision link.
// The slave modport is the sequencer; master is its environment.
interface collision_sweep_if
  import lbm_pkg::*;
#(
  parameter int ADDR_W = 12
);

  logic              start_in;
  logic              pause_in;
  logic              rd_en_out;
  logic [ADDR_W-1:0] rd_addr_out;
  cell_t             rd_data_in;
  cell_t             coll_data_out;
  logic              coll_valid_out;
  cell_t             coll_result_in;
  logic              coll_done_in;
  logic              wr_en_out;
  logic [ADDR_W-1:0] wr_addr_out;
  cell_t             wr_data_out;
  logic              busy_out;
  logic              done_out;
  logic              err_out;

  modport master (
    output start_in, pause_in, rd_data_in,
    output coll_result_in, coll_done_in,
    input  rd_en_out, rd_addr_out,
    input  coll_data_out, coll_valid_out,
    input  wr_en_out, wr_addr_out, wr_data_out,
    input  busy_out, done_out, err_out
  );

  modport slave (
    input  start_in, pause_in, rd_data_in,
    input  coll_result_in, coll_done_in,
    output rd_en_out, rd_addr_out,
    output coll_data_out, coll_valid_out,
    output wr_en_out, wr_addr_out, wr_data_out,
    output busy_out, done_out, err_out
  );

endinterface

// File: rtl/collision_sweep_addr_fifo.sv
// Synchronous FIFO of in-flight cell addresses.
// Pointers carry one extra bit to tell full from empty.
module addr_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 32,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [PW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wp;
  logic [PW:0]      rp;
  logic             do_push;
  logic             do_pop;

  assign count   = wp - rp;
  assign empty   = (wp == rp);
  assign full    = (wp[PW] != rp[PW]) &&
                   (wp[PW-1:0] == rp[PW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[PW-1:0]] <= din;
  end

endmodule

// File: rtl/collision_sweep.sv
// Walks every lattice cell once per frame: BRAM read -> collision ->
// write back to the originating address, one cell per cycle.
module collision_sweep
  import lbm_pkg::*;
#(
  parameter int GRID_W     = 64,
  parameter int GRID_H     = 48,
  parameter int ADDR_W     = 12,
  parameter int BRAM_LAT   = 2,
  parameter int FIFO_DEPTH = 32
) (
  input logic              clk_in,
  input logic              rst_in,
  collision_sweep_if.slave bus
);

  localparam int NCELLS = GRID_W * GRID_H;
  localparam int CW     = ADDR_W + 1;
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int OW     = PW + 1;

  localparam logic [CW-1:0] LAST  = CW'(NCELLS - 1);
  localparam logic [CW-1:0] TOTAL = CW'(NCELLS);
  localparam logic [OW-1:0] THR   =
    OW'(FIFO_DEPTH - BRAM_LAT - 1);

  sweep_state_e state;
  sweep_state_e state_d;

  logic [CW-1:0]       rd_ptr;
  logic [CW-1:0]       wr_count;
  logic [BRAM_LAT-1:0] vld_sr;
  logic                rd_en;
  logic                pop;
  logic                err;
  logic [ADDR_W-1:0]   head;
  logic [OW-1:0]       occ;
  logic                full;
  logic                empty;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  cell_t               wr_data;

  // Throttle leaves room for reads already in the BRAM pipe.
  assign rd_en = (state == S_READ) && !bus.pause_in &&
                 (occ < THR);
  assign pop   = bus.coll_done_in && !empty;

  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= S_IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:  if (bus.start_in) state_d = S_READ;
      S_READ:  if (rd_en && rd_ptr == LAST) state_d = S_DRAIN;
      S_DRAIN: if (wr_count == TOTAL) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rd_ptr   <= '0;
      wr_count <= '0;
      vld_sr   <= '0;
      err      <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      vld_sr <= (vld_sr << 1) | BRAM_LAT'(rd_en);
      if (state == S_IDLE && bus.start_in) begin
        rd_ptr   <= '0;
        wr_count <= '0;
      end else begin
        if (rd_en) rd_ptr   <= rd_ptr + 1'b1;
        if (pop)   wr_count <= wr_count + 1'b1;
      end
      wr_en <= pop;
      if (pop) begin
        wr_addr <= head;
        wr_data <= bus.coll_result_in;
      end
      if ((rd_en && full) || (bus.coll_done_in && empty))
        err <= 1'b1;
    end
  end

  addr_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_in),
    .rst_n (rst_in),
    .push  (rd_en),
    .din   (rd_ptr[ADDR_W-1:0]),
    .pop   (bus.coll_done_in),
    .dout  (head),
    .count (occ),
    .full  (full),
    .empty (empty)
  );

  assign bus.rd_en_out      = rd_en;
  assign bus.rd_addr_out    = rd_en ? rd_ptr[ADDR_W-1:0] : '0;
  assign bus.coll_valid_out = vld_sr[BRAM_LAT-1];
  assign bus.coll_data_out  =
    vld_sr[BRAM_LAT-1] ? bus.rd_data_in : '0;
  assign bus.wr_en_out      = wr_en;
  assign bus.wr_addr_out    = wr_addr;
  assign bus.wr_data_out    = wr_data;
  assign bus.busy_out       = (state != S_IDLE);
  assign bus.done_out       = (state == S_DONE);
  assign bus.err_out        = err;

endmodule

// File: tb/tb_collision_sweep.sv
// Directed bench: 4x2 grid with collision latency 19, plus a full
// 64x48 frame with collision latency 40 against a 32-entry FIFO.
module tb_collision_sweep;
  import lbm_pkg::*;

  localparam int LAT_A = 19;
  localparam int LAT_B = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  collision_sweep_if #(.ADDR_W(12)) ifa ();
  collision_sweep_if #(.ADDR_W(12)) ifb ();

  collision_sweep #(
    .GRID_W(4), .GRID_H(2), .ADDR_W(12),
    .BRAM_LAT(2), .FIFO_DEPTH(32)
  ) dut_a (
    .clk_in(clk), .rst_in(rst), .bus(ifa.slave)
  );

  collision_sweep #(
    .GRID_W(64), .GRID_H(48), .ADDR_W(12),
    .BRAM_LAT(2), .FIFO_DEPTH(32)
  ) dut_b (
    .clk_in(clk), .rst_in(rst), .bus(ifb.slave)
  );

  function automatic cell_t seed(input logic [11:0] a);
    cell_t r;
    for (int j = 0; j < 9; j++) r[j] = {1'b0, a[3:0], 3'(j)};
    return r;
  endfunction

  function automatic cell_t inc(input cell_t c);
    cell_t r;
    for (int j = 0; j < 9; j++) r[j] = c[j] + 8'd1;
    return r;
  endfunction

  // Behavioural BRAMs, read latency 2
  logic [11:0] ba0, ba1, bb0, bb1;
  always @(posedge clk) begin
    ba0 <= ifa.rd_addr_out;
    ba1 <= ba0;
    bb0 <= ifb.rd_addr_out;
    bb1 <= bb0;
  end
  assign ifa.rd_data_in = seed(ba1);
  assign ifb.rd_data_in = seed(bb1);

  // Collision models: fixed latency, each byte + 1
  logic [LAT_A-1:0] cva;
  cell_t            cda [LAT_A];
  logic [LAT_B-1:0] cvb;
  cell_t            cdb [LAT_B];
  logic             inj_a = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      cva <= '0;
      cvb <= '0;
    end else begin
      cva <= {cva[LAT_A-2:0], ifa.coll_valid_out};
      cvb <= {cvb[LAT_B-2:0], ifb.coll_valid_out};
    end
    cda[0] <= inc(ifa.coll_data_out);
    for (int i = 1; i < LAT_A; i++) cda[i] <= cda[i-1];
    cdb[0] <= inc(ifb.coll_data_out);
    for (int i = 1; i < LAT_B; i++) cdb[i] <= cdb[i-1];
  end
  assign ifa.coll_done_in   = cva[LAT_A-1] | inj_a;
  assign ifa.coll_result_in = cda[LAT_A-1];
  assign ifb.coll_done_in   = cvb[LAT_B-1];
  assign ifb.coll_result_in = cdb[LAT_B-1];

  // Event logs for instance A
  logic [11:0] ra_q [$];
  int unsigned rc_q [$];
  logic [11:0] wa_q [$];
  cell_t       wd_q [$];
  int          done_n = 0;
  int unsigned done_cyc = 0;

  always @(negedge clk) begin
    if (ifa.rd_en_out) begin
      ra_q.push_back(ifa.rd_addr_out);
      rc_q.push_back(cyc);
    end
    if (ifa.wr_en_out) begin
      wa_q.push_back(ifa.wr_addr_out);
      wd_q.push_back(ifa.wr_data_out);
    end
    if (ifa.done_out) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  // Bookkeeping for instance B
  bit seen_b [4096];
  int wcnt_b = 0, dup_b = 0, occ_b = 0, occ_max_b = 0;
  int done_b = 0;

  always @(negedge clk) begin
    if (ifb.wr_en_out) begin
      if (seen_b[ifb.wr_addr_out]) dup_b++;
      else seen_b[ifb.wr_addr_out] = 1'b1;
      wcnt_b++;
    end
    occ_b = occ_b + (ifb.rd_en_out ? 1 : 0)
                  - (ifb.coll_done_in ? 1 : 0);
    if (occ_b > occ_max_b) occ_max_b = occ_b;
    if (ifb.done_out) done_b++;
  end

  task automatic clear_a();
    ra_q.delete();
    rc_q.delete();
    wa_q.delete();
    wd_q.delete();
    done_n = 0;
  endtask

  task automatic start_a(output int unsigned s);
    @(negedge clk);
    ifa.start_in = 1'b1;
    s = cyc;
    @(negedge clk);
    ifa.start_in = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_n > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({ifa.rd_en_out, ifa.coll_valid_out, ifa.wr_en_out} !== 3'b0) begin
      bad++;
      $display("FAIL reset_strobes: got %b want 000",
        {ifa.rd_en_out, ifa.coll_valid_out, ifa.wr_en_out});
    end
    total++;
    if ({ifa.busy_out, ifa.done_out, ifa.err_out} !== 3'b0) begin
      bad++;
      $display("FAIL reset_status: got %b want 000",
        {ifa.busy_out, ifa.done_out, ifa.err_out});
    end
    total++;
    if ({ifa.rd_addr_out, ifa.wr_addr_out} !== 24'h0) begin
      bad++;
      $display("FAIL reset_addr: got %h want 0",
        {ifa.rd_addr_out, ifa.wr_addr_out});
    end
    total++;
    if ({ifa.coll_data_out, ifa.wr_data_out} !== '0) begin
      bad++;
      $display("FAIL reset_data: got %h %h want 0",
        ifa.coll_data_out, ifa.wr_data_out);
    end
    total++;
    if ({ifb.busy_out, ifb.err_out, ifb.rd_en_out} !== 3'b0) begin
      bad++;
      $display("FAIL reset_b: got %b want 000",
        {ifb.busy_out, ifb.err_out, ifb.rd_en_out});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int unsigned s;
    bit ok;
    clear_a();
    start_a(s);
    wait_done_a(100, ok);
    repeat (5) @(negedge clk);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL basic_done_timeout: got none want pulse");
    end
    total++;
    if (done_cyc - s !== 31) begin
      bad++;
      $display("FAIL basic_latency: got %0d want 31", done_cyc - s);
    end
    total++;
    if (done_n !== 1) begin
      bad++;
      $display("FAIL basic_done_count: got %0d want 1", done_n);
    end
    total++;
    if (ra_q.size() !== 8) begin
      bad++;
      $display("FAIL basic_reads: got %0d want 8", ra_q.size());
    end
    for (int i = 0; i < 8 && i < ra_q.size(); i++) begin
      total++;
      if (ra_q[i] !== 12'(i) || rc_q[i] !== s + 1 + i) begin
        bad++;
        $display("FAIL basic_rd[%0d]: got a=%0d c=%0d want a=%0d c=%0d",
          i, ra_q[i], rc_q[i] - s, i, i + 1);
      end
    end
    total++;
    if (wa_q.size() !== 8) begin
      bad++;
      $display("FAIL basic_writes: got %0d want 8", wa_q.size());
    end
    for (int i = 0; i < 8 && i < wa_q.size(); i++) begin
      total++;
      if (wa_q[i] !== 12'(i) || wd_q[i] !== inc(seed(12'(i)))) begin
        bad++;
        $display("FAIL basic_wr[%0d]: got a=%0d d=%h want a=%0d d=%h",
          i, wa_q[i], wd_q[i], i, inc(seed(12'(i))));
      end
    end
    total++;
    if (ifa.busy_out !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle: got busy=%b want 0", ifa.busy_out);
    end
  endtask

  task automatic test_pause();
    int unsigned s;
    bit ok;
    int viol = 0;
    int n0;
    clear_a();
    start_a(s);
    for (int i = 0; i < 50 && ra_q.size() < 3; i++) @(negedge clk);
    @(posedge clk);
    #1 ifa.pause_in = 1'b1;
    n0 = ra_q.size();
    repeat (5) begin
      @(negedge clk);
      #1;
      if (ifa.rd_en_out) viol++;
    end
    @(posedge clk);
    #1 ifa.pause_in = 1'b0;
    total++;
    if (viol !== 0 || ra_q.size() !== n0) begin
      bad++;
      $display("FAIL pause_reads: got %0d reads want 0",
        viol + ra_q.size() - n0);
    end
    wait_done_a(120, ok);
    repeat (3) @(negedge clk);
    total++;
    if (!ok || done_n !== 1) begin
      bad++;
      $display("FAIL pause_done: got %0d want 1", done_n);
    end
    total++;
    if (wa_q.size() !== 8 || ra_q.size() !== 8) begin
      bad++;
      $display("FAIL pause_count: got w=%0d r=%0d want 8",
        wa_q.size(), ra_q.size());
    end
    for (int i = 0; i < 8 && i < wa_q.size(); i++) begin
      total++;
      if (wa_q[i] !== 12'(i)) begin
        bad++;
        $display("FAIL pause_order[%0d]: got %0d want %0d",
          i, wa_q[i], i);
      end
    end
  endtask

  task automatic test_restart();
    int unsigned s;
    int drop = 0;
    clear_a();
    start_a(s);
    repeat (3) @(negedge clk);
    ifa.start_in = 1'b1;
    @(negedge clk);
    ifa.start_in = 1'b0;
    for (int i = 0; i < 100 && done_n == 0; i++) begin
      if (!ifa.busy_out) drop++;
      @(negedge clk);
    end
    repeat (40) @(negedge clk);
    total++;
    if (done_n !== 1) begin
      bad++;
      $display("FAIL restart_done: got %0d want 1", done_n);
    end
    total++;
    if (drop !== 0) begin
      bad++;
      $display("FAIL restart_busy: got %0d low cycles want 0", drop);
    end
    total++;
    if (wa_q.size() !== 8 || ra_q.size() !== 8) begin
      bad++;
      $display("FAIL restart_count: got w=%0d r=%0d want 8",
        wa_q.size(), ra_q.size());
    end
  endtask

  task automatic test_spurious();
    total++;
    if (ifa.err_out !== 1'b0) begin
      bad++;
      $display("FAIL spur_pre_err: got %b want 0", ifa.err_out);
    end
    clear_a();
    @(negedge clk);
    inj_a = 1'b1;
    @(negedge clk);
    inj_a = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (wa_q.size() !== 0) begin
      bad++;
      $display("FAIL spur_write: got %0d want 0", wa_q.size());
    end
    total++;
    if (ifa.err_out !== 1'b1) begin
      bad++;
      $display("FAIL spur_err: got %b want 1", ifa.err_out);
    end
    repeat (10) @(negedge clk);
    total++;
    if (ifa.err_out !== 1'b1 || ifa.busy_out !== 1'b0) begin
      bad++;
      $display("FAIL spur_hold: got err=%b busy=%b want 1 0",
        ifa.err_out, ifa.busy_out);
    end
  endtask

  task automatic test_midreset();
    int unsigned s;
    bit ok;
    clear_a();
    start_a(s);
    for (int i = 0; i < 100 && wa_q.size() < 3; i++) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({ifa.rd_en_out, ifa.coll_valid_out, ifa.wr_en_out,
         ifa.busy_out, ifa.done_out, ifa.err_out} !== 6'b0) begin
      bad++;
      $display("FAIL midrst_flags: got %b want 000000",
        {ifa.rd_en_out, ifa.coll_valid_out, ifa.wr_en_out,
         ifa.busy_out, ifa.done_out, ifa.err_out});
    end
    total++;
    if ({ifa.rd_addr_out, ifa.wr_addr_out, ifa.coll_data_out,
         ifa.wr_data_out} !== '0) begin
      bad++;
      $display("FAIL midrst_bus: got wa=%h wd=%h want 0",
        ifa.wr_addr_out, ifa.wr_data_out);
    end
    rst = 1'b1;
    clear_a();
    repeat (60) @(negedge clk);
    total++;
    if (wa_q.size() !== 0 || ra_q.size() !== 0 || done_n !== 0) begin
      bad++;
      $display("FAIL midrst_quiet: got w=%0d r=%0d d=%0d want 0",
        wa_q.size(), ra_q.size(), done_n);
    end
    start_a(s);
    wait_done_a(100, ok);
    repeat (3) @(negedge clk);
    total++;
    if (!ok || done_n !== 1 || wa_q.size() !== 8) begin
      bad++;
      $display("FAIL midrst_frame: got d=%0d w=%0d want 1 8",
        done_n, wa_q.size());
    end
    for (int i = 0; i < 8 && i < wa_q.size(); i++) begin
      total++;
      if (wa_q[i] !== 12'(i)) begin
        bad++;
        $display("FAIL midrst_wr[%0d]: got %0d want %0d",
          i, wa_q[i], i);
      end
    end
  endtask

  task automatic test_full_frame();
    int missing = 0;
    @(negedge clk);
    ifb.start_in = 1'b1;
    @(negedge clk);
    ifb.start_in = 1'b0;
    for (int i = 0; i < 20000 && done_b == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    for (int a = 0; a < NCELLS; a++) if (!seen_b[a]) missing++;
    total++;
    if (done_b !== 1) begin
      bad++;
      $display("FAIL big_done: got %0d want 1", done_b);
    end
    total++;
    if (ifb.err_out !== 1'b0) begin
      bad++;
      $display("FAIL big_err: got %b want 0", ifb.err_out);
    end
    total++;
    if (wcnt_b !== NCELLS || dup_b !== 0 || missing !== 0) begin
      bad++;
      $display("FAIL big_cells: got w=%0d dup=%0d miss=%0d want %0d 0 0",
        wcnt_b, dup_b, missing, NCELLS);
    end
    total++;
    if (occ_max_b > 32) begin
      bad++;
      $display("FAIL big_occ: got %0d want <=32", occ_max_b);
    end
  endtask

  initial begin
    ifa.start_in = 1'b0;
    ifa.pause_in = 1'b0;
    ifb.start_in = 1'b0;
    ifb.pause_in = 1'b0;
    test_reset();
    test_basic();
    test_pause();
    test_restart();
    test_spurious();
    test_midreset();
    test_full_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
